// File: rtl/zcr_ste_pkg.sv
// rtl/zcr_ste_pkg.sv - shared defaults, clog2 helper and FSM encoding for zcr_ste_frame
package zcr_ste_pkg;

  localparam int DEF_DATA_WIDTH   = 16;
  localparam int DEF_FRAME_LEN    = 256;
  localparam int DEF_ENERGY_SHIFT = 8;
  localparam int DEF_ENERGY_WIDTH = 32;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

  localparam int DEF_ACC_WIDTH = 2 * DEF_DATA_WIDTH + clog2(DEF_FRAME_LEN);
  localparam int DEF_ZCR_WIDTH = clog2(DEF_FRAME_LEN) + 1;

  localparam logic [0:0] NO_PREV = 1'b0;
  localparam logic [0:0] ACCUM   = 1'b1;

endpackage

// File: rtl/zcr_ste_frame_sq_acc.sv
// rtl/zcr_ste_frame_sq_acc.sv - square, frame accumulate (load on first), shift and saturate
module sq_acc
  import zcr_ste_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int FRAME_LEN    = DEF_FRAME_LEN,
  parameter int ENERGY_SHIFT = DEF_ENERGY_SHIFT,
  parameter int ENERGY_WIDTH = DEF_ENERGY_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic                    in_first,
  input  logic [DATA_WIDTH-1:0]   in_data,
  output logic [ENERGY_WIDTH-1:0] energy,
  output logic                    sat
);

  localparam int SQ_W  = 2 * DATA_WIDTH;
  localparam int ACC_W = SQ_W + clog2(FRAME_LEN);

  logic [SQ_W-1:0]  sq_ext;
  logic [SQ_W-1:0]  sq_full;
  logic [SQ_W-1:0]  sq_d, sq_q;
  logic             valid_d, valid_q;
  logic             first_d, first_q;
  logic [ACC_W-1:0] acc_d, acc_q;
  logic [ACC_W-1:0] shifted;

  // Low half of the sign-extended product is the exact signed square (it always fits).
  assign sq_ext  = {{DATA_WIDTH{in_data[DATA_WIDTH-1]}}, in_data};
  assign sq_full = sq_ext * sq_ext;

  always_comb begin
    valid_d = in_valid;
    first_d = first_q;
    sq_d    = sq_q;
    if (in_valid) begin
      first_d = in_first;
      sq_d    = sq_full;
    end
    acc_d = acc_q;
    if (valid_q) begin
      acc_d = first_q ? ACC_W'(sq_q) : acc_q + ACC_W'(sq_q);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      first_q <= 1'b0;
      sq_q    <= '0;
      acc_q   <= '0;
    end else begin
      valid_q <= valid_d;
      first_q <= first_d;
      sq_q    <= sq_d;
      acc_q   <= acc_d;
    end
  end

  assign shifted = acc_q >> ENERGY_SHIFT;

  generate
    if (ACC_W > ENERGY_WIDTH) begin : g_sat
      assign sat    = |shifted[ACC_W-1:ENERGY_WIDTH];
      assign energy = sat ? {ENERGY_WIDTH{1'b1}} : shifted[ENERGY_WIDTH-1:0];
    end else begin : g_nosat
      assign sat    = 1'b0;
      assign energy = ENERGY_WIDTH'(shifted);
    end
  endgenerate

endmodule

// File: rtl/zcr_ste_frame.sv
// rtl/zcr_ste_frame.sv - per-frame zero-crossing count and short-time energy
module zcr_ste_frame
  import zcr_ste_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int FRAME_LEN    = DEF_FRAME_LEN,
  parameter int ZCR_WIDTH    = DEF_ZCR_WIDTH,
  parameter int ENERGY_SHIFT = DEF_ENERGY_SHIFT,
  parameter int ENERGY_WIDTH = DEF_ENERGY_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic                    data_valid,
  output logic [ZCR_WIDTH-1:0]    zcr_out,
  output logic [ENERGY_WIDTH-1:0] ste_out,
  output logic                    frame_valid,
  output logic                    overflow
);

  localparam int              CNT_W    = clog2(FRAME_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);

  logic [0:0]              state_d, state_q;
  logic                    prev_sign_d, prev_sign_q;
  logic [CNT_W-1:0]        cnt_d, cnt_q;
  logic                    s1_valid_d, s1_valid_q;
  logic                    s1_cross_d, s1_cross_q;
  logic                    s1_first_d, s1_first_q;
  logic                    s1_last_d, s1_last_q;
  logic [ZCR_WIDTH-1:0]    zacc_d, zacc_q;
  logic                    s2_last_d, s2_last_q;
  logic [ZCR_WIDTH-1:0]    zcr_d, zcr_q;
  logic [ENERGY_WIDTH-1:0] ste_d, ste_q;
  logic                    fv_d, fv_q;
  logic                    ovf_d, ovf_q;
  logic                    sign;
  logic                    first_smp;
  logic [ENERGY_WIDTH-1:0] energy;
  logic                    sat;

  assign sign      = data_in[DATA_WIDTH-1];
  assign first_smp = (cnt_q == '0);

  sq_acc #(
    .DATA_WIDTH  (DATA_WIDTH),
    .FRAME_LEN   (FRAME_LEN),
    .ENERGY_SHIFT(ENERGY_SHIFT),
    .ENERGY_WIDTH(ENERGY_WIDTH)
  ) u_sq_acc (
    .clk     (clk),
    .reset   (reset),
    .in_valid(data_valid),
    .in_first(first_smp),
    .in_data (data_in),
    .energy  (energy),
    .sat     (sat)
  );

  always_comb begin
    state_d     = state_q;
    prev_sign_d = prev_sign_q;
    cnt_d       = cnt_q;
    if (data_valid) begin
      state_d     = ACCUM;
      prev_sign_d = sign;
      cnt_d       = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    end

    // Previous sign survives frame boundaries, so a boundary crossing lands in the new frame.
    s1_valid_d = data_valid;
    s1_cross_d = data_valid && (state_q == ACCUM) && (sign != prev_sign_q);
    s1_first_d = first_smp;
    s1_last_d  = data_valid && (cnt_q == CNT_LAST);

    zacc_d = zacc_q;
    if (s1_valid_q) begin
      zacc_d = s1_first_q ? ZCR_WIDTH'(s1_cross_q) : zacc_q + ZCR_WIDTH'(s1_cross_q);
    end
    s2_last_d = s1_last_q;

    fv_d  = s2_last_q;
    zcr_d = s2_last_q ? zacc_q : zcr_q;
    ste_d = s2_last_q ? energy : ste_q;
    ovf_d = ovf_q | (s2_last_q & sat);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= NO_PREV;
      prev_sign_q <= 1'b0;
      cnt_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_cross_q  <= 1'b0;
      s1_first_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      zacc_q      <= '0;
      s2_last_q   <= 1'b0;
      zcr_q       <= '0;
      ste_q       <= '0;
      fv_q        <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_sign_q <= prev_sign_d;
      cnt_q       <= cnt_d;
      s1_valid_q  <= s1_valid_d;
      s1_cross_q  <= s1_cross_d;
      s1_first_q  <= s1_first_d;
      s1_last_q   <= s1_last_d;
      zacc_q      <= zacc_d;
      s2_last_q   <= s2_last_d;
      zcr_q       <= zcr_d;
      ste_q       <= ste_d;
      fv_q        <= fv_d;
      ovf_q       <= ovf_d;
    end
  end

  assign zcr_out     = zcr_q;
  assign ste_out     = ste_q;
  assign frame_valid = fv_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_zcr_ste_frame.sv
// tb/tb_zcr_ste_frame.sv - directed bench for zcr_ste_frame (FRAME_LEN=8; 32- and 16-bit energy)
module tb_zcr_ste_frame;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] data_in = 16'h0;
  logic        data_valid = 1'b0;

  logic [3:0]  zcr_a, zcr_b;
  logic [31:0] ste_a;
  logic [15:0] ste_b;
  logic        fv_a, fv_b, ovf_a, ovf_b;

  int total = 0;
  int bad = 0;

  logic [15:0] stim_d[$];
  logic        stim_v[$];
  int          pc_a[$];
  logic [3:0]  pz_a[$];
  logic [31:0] ps_a[$];
  int          pc_b[$];
  logic [3:0]  pz_b[$];
  logic [15:0] ps_b[$];

  always #5 clk = ~clk;

  zcr_ste_frame #(
    .DATA_WIDTH(16), .FRAME_LEN(8), .ZCR_WIDTH(4), .ENERGY_SHIFT(0), .ENERGY_WIDTH(32)
  ) dut_a (
    .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
    .zcr_out(zcr_a), .ste_out(ste_a), .frame_valid(fv_a), .overflow(ovf_a)
  );

  zcr_ste_frame #(
    .DATA_WIDTH(16), .FRAME_LEN(8), .ZCR_WIDTH(4), .ENERGY_SHIFT(0), .ENERGY_WIDTH(16)
  ) dut_b (
    .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
    .zcr_out(zcr_b), .ste_out(ste_b), .frame_valid(fv_b), .overflow(ovf_b)
  );

  task automatic push(input logic [15:0] d, input logic v);
    stim_d.push_back(d);
    stim_v.push_back(v);
  endtask

  // Called at a negedge; cycle index i is the posedge that accepts stim[i].
  task automatic run_stim(input int extra);
    int n;
    n = stim_d.size();
    pc_a.delete(); pz_a.delete(); ps_a.delete();
    pc_b.delete(); pz_b.delete(); ps_b.delete();
    for (int i = 0; i < n + extra; i++) begin
      if (i < n) begin
        data_in = stim_d[i];
        data_valid = stim_v[i];
      end else begin
        data_in = 16'h7fff;
        data_valid = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      if (fv_a) begin pc_a.push_back(i); pz_a.push_back(zcr_a); ps_a.push_back(ste_a); end
      if (fv_b) begin pc_b.push_back(i); pz_b.push_back(zcr_b); ps_b.push_back(ste_b); end
    end
    data_valid = 1'b0;
    stim_d.delete();
    stim_v.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    data_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    total++; if (zcr_a !== 4'd0) begin bad++; $display("FAIL reset_zcr_a got=%0d want=0", zcr_a); end
    total++; if (ste_a !== 32'd0) begin bad++; $display("FAIL reset_ste_a got=%0d want=0", ste_a); end
    total++; if (fv_a !== 1'b0) begin bad++; $display("FAIL reset_fv_a got=%b want=0", fv_a); end
    total++; if (ovf_a !== 1'b0) begin bad++; $display("FAIL reset_ovf_a got=%b want=0", ovf_a); end
    total++; if (ste_b !== 16'd0) begin bad++; $display("FAIL reset_ste_b got=%0d want=0", ste_b); end
    total++; if (ovf_b !== 1'b0) begin bad++; $display("FAIL reset_ovf_b got=%b want=0", ovf_b); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_alternating();
    int          ec[2] = '{9, 17};
    logic [3:0]  ez[2] = '{4'd7, 4'd8};
    do_reset();
    for (int i = 0; i < 16; i++) push((i % 2) ? 16'hFF9C : 16'd100, 1'b1);
    run_stim(4);
    total++; if (pc_a.size() != 2) begin bad++; $display("FAIL alt_pulses got=%0d want=2", pc_a.size()); end
    for (int k = 0; k < pc_a.size() && k < 2; k++) begin
      total++; if (pc_a[k] != ec[k]) begin bad++; $display("FAIL alt_cycle%0d got=%0d want=%0d", k, pc_a[k], ec[k]); end
      total++; if (pz_a[k] !== ez[k]) begin bad++; $display("FAIL alt_zcr%0d got=%0d want=%0d", k, pz_a[k], ez[k]); end
      total++; if (ps_a[k] !== 32'd80000) begin bad++; $display("FAIL alt_ste%0d got=%0d want=80000", k, ps_a[k]); end
    end
  endtask

  task automatic test_constant();
    do_reset();
    for (int i = 0; i < 8; i++) push(16'd5, 1'b1);
    run_stim(4);
    total++; if (pc_a.size() != 1) begin bad++; $display("FAIL const_pulses got=%0d want=1", pc_a.size()); end
    if (pc_a.size() == 1) begin
      total++; if (pz_a[0] !== 4'd0) begin bad++; $display("FAIL const_zcr got=%0d want=0", pz_a[0]); end
      total++; if (ps_a[0] !== 32'd200) begin bad++; $display("FAIL const_ste got=%0d want=200", ps_a[0]); end
    end
    total++; if (ovf_a !== 1'b0) begin bad++; $display("FAIL const_ovf got=%b want=0", ovf_a); end
  endtask

  task automatic test_sparse_valid();
    do_reset();
    for (int k = 0; k < 8; k++) begin
      push((k % 2) ? 16'hFFFF : 16'h0000, 1'b1);
      push(16'h8000, 1'b0);
      push(16'h8000, 1'b0);
    end
    run_stim(4);
    total++; if (pc_a.size() != 1) begin bad++; $display("FAIL sparse_pulses got=%0d want=1", pc_a.size()); end
    if (pc_a.size() == 1) begin
      total++; if (pc_a[0] != 23) begin bad++; $display("FAIL sparse_cycle got=%0d want=23", pc_a[0]); end
      total++; if (pz_a[0] !== 4'd7) begin bad++; $display("FAIL sparse_zcr got=%0d want=7", pz_a[0]); end
      total++; if (ps_a[0] !== 32'd4) begin bad++; $display("FAIL sparse_ste got=%0d want=4", ps_a[0]); end
    end
  endtask

  task automatic test_saturate();
    logic [3:0]  ez[2] = '{4'd0, 4'd1};
    logic [15:0] es[2] = '{16'hFFFF, 16'd8};
    do_reset();
    for (int i = 0; i < 8; i++) push(16'h8000, 1'b1);
    for (int i = 0; i < 8; i++) push(16'd1, 1'b1);
    run_stim(4);
    total++; if (pc_b.size() != 2) begin bad++; $display("FAIL sat_pulses got=%0d want=2", pc_b.size()); end
    for (int k = 0; k < pc_b.size() && k < 2; k++) begin
      total++; if (pz_b[k] !== ez[k]) begin bad++; $display("FAIL sat_zcr%0d got=%0d want=%0d", k, pz_b[k], ez[k]); end
      total++; if (ps_b[k] !== es[k]) begin bad++; $display("FAIL sat_ste%0d got=%0d want=%0d", k, ps_b[k], es[k]); end
    end
    total++; if (ovf_b !== 1'b1) begin bad++; $display("FAIL sat_ovf_b got=%b want=1", ovf_b); end
    if (ps_a.size() >= 1) begin
      total++; if (ps_a[0] !== 32'hFFFFFFFF) begin bad++; $display("FAIL sat_ste_a got=%h want=ffffffff", ps_a[0]); end
    end
    total++; if (ovf_a !== 1'b1) begin bad++; $display("FAIL sat_ovf_a got=%b want=1", ovf_a); end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 5; i++) push(16'(i * 7 - 9), 1'b1);
    run_stim(0);
    reset = 1'b1;
    #1;
    total++; if (zcr_a !== 4'd0) begin bad++; $display("FAIL midrst_zcr got=%0d want=0", zcr_a); end
    total++; if (ste_a !== 32'd0) begin bad++; $display("FAIL midrst_ste got=%0d want=0", ste_a); end
    total++; if (ovf_a !== 1'b0) begin bad++; $display("FAIL midrst_ovf got=%b want=0", ovf_a); end
    total++; if (fv_a !== 1'b0) begin bad++; $display("FAIL midrst_fv got=%b want=0", fv_a); end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) push((i % 2) ? 16'hFFFD : 16'd3, 1'b1);
    run_stim(4);
    total++; if (pc_a.size() != 1) begin bad++; $display("FAIL midrst_pulses got=%0d want=1", pc_a.size()); end
    if (pc_a.size() == 1) begin
      total++; if (pz_a[0] !== 4'd7) begin bad++; $display("FAIL midrst_zcr2 got=%0d want=7", pz_a[0]); end
      total++; if (ps_a[0] !== 32'd72) begin bad++; $display("FAIL midrst_ste2 got=%0d want=72", ps_a[0]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] smp[64];
    logic [3:0]  exp_z[8];
    logic [31:0] exp_e[8];
    logic        exp_ovf;
    logic        have_prev;
    logic        prev_s;
    logic [63:0] e;
    longint      v;
    int          z;
    do_reset();
    for (int i = 0; i < 64; i++) begin
      smp[i] = 16'($urandom);
      push(smp[i], 1'b1);
    end
    have_prev = 1'b0;
    prev_s = 1'b0;
    exp_ovf = 1'b0;
    for (int f = 0; f < 8; f++) begin
      z = 0;
      e = 64'd0;
      for (int k = 0; k < 8; k++) begin
        if (have_prev && (smp[f*8+k][15] != prev_s)) z++;
        have_prev = 1'b1;
        prev_s = smp[f*8+k][15];
        v = longint'($signed(smp[f*8+k]));
        e = e + 64'(v * v);
      end
      exp_z[f] = 4'(z);
      if (e > 64'h0000_0000_FFFF_FFFF) begin
        exp_e[f] = 32'hFFFFFFFF;
        exp_ovf = 1'b1;
      end else begin
        exp_e[f] = e[31:0];
      end
    end
    run_stim(4);
    total++; if (pc_a.size() != 8) begin bad++; $display("FAIL b2b_pulses got=%0d want=8", pc_a.size()); end
    for (int f = 0; f < pc_a.size() && f < 8; f++) begin
      total++; if (pc_a[f] != 9 + 8 * f) begin bad++; $display("FAIL b2b_cycle%0d got=%0d want=%0d", f, pc_a[f], 9 + 8 * f); end
      total++; if (pz_a[f] !== exp_z[f]) begin bad++; $display("FAIL b2b_zcr%0d got=%0d want=%0d", f, pz_a[f], exp_z[f]); end
      total++; if (ps_a[f] !== exp_e[f]) begin bad++; $display("FAIL b2b_ste%0d got=%0d want=%0d", f, ps_a[f], exp_e[f]); end
    end
    total++; if (ovf_a !== exp_ovf) begin bad++; $display("FAIL b2b_ovf got=%b want=%b", ovf_a, exp_ovf); end
  endtask

  initial begin
    test_reset();
    test_alternating();
    test_constant();
    test_sparse_valid();
    test_saturate();
    test_mid_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
